rwc_chal_seq: RTL and testbench

- Challenge sequencer and response voter sitting directly upstream of the read-write-collision generator.
- Produces a pseudo-random challenge stream (32-bit data, 10-bit address) from a seeded LFSR and drives the generator's enable/available handshake.
- Repeats each challenge REPS times, majority-votes rsp_write per bit, and emits one voted response word plus a stability mask per challenge on a valid/ready port toward the enrollment/readout logic.

---
 rtl/rwc_chal_seq.sv | 233 +++++++++++++++++++++++
 tb/tb_rwc_chal_seq.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rwc_chal_seq.sv
// rwc_chal_seq: challenge sequencer and majority voter placed in front of the
// read-write-collision generator. A seeded Galois LFSR supplies each challenge,
// every challenge is replayed REPS times, and rsp_write is voted per bit into
// one response word plus a unanimity mask, handed off on a valid/ready port.
// Optional feature: define RWC_CLEAN_CHECK_EN to flag any non-zero rsp_clean
// seen in CAPTURE on the sticky clean_err output; otherwise clean_err is 0.
module rwc_chal_seq #(
   parameter int NUM_CHAL = 16,
   parameter int REPS     = 5,
   parameter int TIMEOUT  = 64
) (
   input  logic        clk,
   input  logic        w_resetn,
   input  logic        start,
   input  logic [31:0] seed,
   output logic        busy,
   output logic        done,
   output logic        err,
   output logic        clean_err,
   output logic        gen_enable,
   output logic [31:0] cha_data,
   output logic [9:0]  cha_addr,
   input  logic        gen_available,
   input  logic [31:0] rsp_write,
   input  logic [31:0] rsp_clean,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_data,
   output logic [31:0] out_mask,
   output logic [9:0]  out_index
);

   localparam int          TW       = $clog2(TIMEOUT + 1);
   localparam logic [31:0] POLY     = 32'h8020_0003;
   localparam logic [3:0]  HALF     = 4'(REPS / 2);
   localparam logic [3:0]  REPS4    = 4'(REPS);
   localparam logic [9:0]  LAST_IDX = 10'(NUM_CHAL - 1);
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT_LO,
      S_WAIT_HI,
      S_CAPTURE,
      S_EMIT,
      S_FIN
   } state_t;

   state_t        state_reg;
   logic [31:0]   lfsr_reg;
   logic [9:0]    idx_reg;
   logic [3:0]    rep_reg;
   logic [TW-1:0] tmo_reg;

   logic          busy_reg;
   logic          done_reg;
   logic          err_reg;
   logic          clean_err_reg;
   logic          gen_enable_reg;
   logic [31:0]   cha_data_reg;
   logic [9:0]    cha_addr_reg;
   logic          out_valid_reg;
   logic [31:0]   out_data_reg;
   logic [31:0]   out_mask_reg;
   logic [9:0]    out_index_reg;

   logic [31:0]   lfsr_next;
   logic [31:0]   seed_eff;
   logic [3:0]    rep_next;
   logic          start_accept;
   logic          hs;
   logic          cnt_clr;
   logic          cnt_add;
   logic [31:0]   vote_bit;
   logic [31:0]   stable_bit;

   // Galois step and seed fix-up (an all-zero state would lock the LFSR)
   assign lfsr_next    = (lfsr_reg >> 1) ^ (lfsr_reg[0] ? POLY : 32'd0);
   assign seed_eff     = (seed == 32'd0) ? 32'd1 : seed;
   assign rep_next     = rep_reg + 4'd1;
   assign start_accept = (state_reg == S_IDLE) && start;
   assign hs           = out_valid_reg && out_ready;
   assign cnt_clr      = start_accept || hs;
   assign cnt_add      = (state_reg == S_CAPTURE);

   // Per-bit vote counters; the vote and mask look at the count including the
   // response being captured so the last repetition lands in EMIT directly.
   generate
      for (genvar gi = 0; gi < 32; gi++) begin : g_bit
         logic [3:0] cnt_reg;
         logic [3:0] cnt_sum;

         assign cnt_sum        = cnt_reg + {3'b000, rsp_write[gi]};
         assign vote_bit[gi]   = (cnt_sum > HALF);
         assign stable_bit[gi] = (cnt_sum == 4'd0) || (cnt_sum == REPS4);

         // Accumulate this bit's ones across the repetitions of a challenge
         always_ff @(posedge clk) begin
            if (!w_resetn || cnt_clr)
               cnt_reg <= 4'd0;
            else if (cnt_add)
               cnt_reg <= cnt_sum;
         end
      end
   endgenerate

   // Main sequencer: issue, handshake with the generator, capture, emit
   always_ff @(posedge clk) begin
      if (!w_resetn) begin
         state_reg      <= S_IDLE;
         lfsr_reg       <= 32'd1;
         idx_reg        <= 10'd0;
         rep_reg        <= 4'd0;
         tmo_reg        <= '0;
         busy_reg       <= 1'b0;
         done_reg       <= 1'b0;
         err_reg        <= 1'b0;
         clean_err_reg  <= 1'b0;
         gen_enable_reg <= 1'b0;
         cha_data_reg   <= 32'd0;
         cha_addr_reg   <= 10'd0;
         out_valid_reg  <= 1'b0;
         out_data_reg   <= 32'd0;
         out_mask_reg   <= 32'd0;
         out_index_reg  <= 10'd0;
      end else begin
         gen_enable_reg <= 1'b0;
         done_reg       <= 1'b0;
         case (state_reg)
            S_IDLE: begin
               if (start) begin
                  lfsr_reg       <= seed_eff;
                  cha_data_reg   <= seed_eff;
                  cha_addr_reg   <= seed_eff[9:0];
                  idx_reg        <= 10'd0;
                  rep_reg        <= 4'd0;
                  err_reg        <= 1'b0;
                  clean_err_reg  <= 1'b0;
                  busy_reg       <= 1'b1;
                  gen_enable_reg <= 1'b1;
                  state_reg      <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               tmo_reg   <= '0;
               state_reg <= S_WAIT_LO;
            end
            S_WAIT_LO: begin
               if (!gen_available) begin
                  tmo_reg   <= '0;
                  state_reg <= S_WAIT_HI;
               end else if (tmo_reg == TMO_LAST) begin
                  err_reg   <= 1'b1;
                  done_reg  <= 1'b1;
                  state_reg <= S_FIN;
               end else begin
                  tmo_reg <= tmo_reg + 1'b1;
               end
            end
            S_WAIT_HI: begin
               if (gen_available) begin
                  state_reg <= S_CAPTURE;
               end else if (tmo_reg == TMO_LAST) begin
                  err_reg   <= 1'b1;
                  done_reg  <= 1'b1;
                  state_reg <= S_FIN;
               end else begin
                  tmo_reg <= tmo_reg + 1'b1;
               end
            end
            S_CAPTURE: begin
               rep_reg <= rep_next;
`ifdef RWC_CLEAN_CHECK_EN
               if (rsp_clean != 32'd0)
                  clean_err_reg <= 1'b1;
`endif
               if (rep_next == REPS4) begin
                  out_valid_reg <= 1'b1;
                  out_data_reg  <= vote_bit;
                  out_mask_reg  <= stable_bit;
                  out_index_reg <= idx_reg;
                  state_reg     <= S_EMIT;
               end else begin
                  gen_enable_reg <= 1'b1;
                  state_reg      <= S_ISSUE;
               end
            end
            S_EMIT: begin
               if (out_ready) begin
                  out_valid_reg <= 1'b0;
                  rep_reg       <= 4'd0;
                  lfsr_reg      <= lfsr_next;
                  cha_data_reg  <= lfsr_next;
                  cha_addr_reg  <= lfsr_next[9:0];
                  idx_reg       <= idx_reg + 10'd1;
                  if (idx_reg == LAST_IDX) begin
                     done_reg  <= 1'b1;
                     state_reg <= S_FIN;
                  end else begin
                     gen_enable_reg <= 1'b1;
                     state_reg      <= S_ISSUE;
                  end
               end
            end
            S_FIN: begin
               busy_reg  <= 1'b0;
               state_reg <= S_IDLE;
            end
            default: state_reg <= S_IDLE;
         endcase
      end
   end

`ifndef RWC_CLEAN_CHECK_EN
   // Clear-phase response is not inspected in this build
   logic unused_clean;
   assign unused_clean = ^rsp_clean;
`endif

   assign busy       = busy_reg;
   assign done       = done_reg;
   assign err        = err_reg;
   assign clean_err  = clean_err_reg;
   assign gen_enable = gen_enable_reg;
   assign cha_data   = cha_data_reg;
   assign cha_addr   = cha_addr_reg;
   assign out_valid  = out_valid_reg;
   assign out_data   = out_data_reg;
   assign out_mask   = out_mask_reg;
   assign out_index  = out_index_reg;

endmodule

// File: tb/tb_rwc_chal_seq.sv
// tb_rwc_chal_seq: directed bench for rwc_chal_seq with a small generator stub
// (drops gen_available for two cycles after each gen_enable and replays a
// per-repetition response table). Build with +define+RWC_CLEAN_CHECK_EN to
// exercise the clear-phase check.
module tb_rwc_chal_seq;

   localparam int TO = 20;

`ifdef RWC_CLEAN_CHECK_EN
   localparam logic [31:0] CLEAN_EXP = 32'd1;
`else
   localparam logic [31:0] CLEAN_EXP = 32'd0;
`endif

   logic        clk;
   logic        w_resetn;
   logic        start;
   logic [31:0] seed;
   logic        busy;
   logic        done;
   logic        err;
   logic        clean_err;
   logic        gen_enable;
   logic [31:0] cha_data;
   logic [9:0]  cha_addr;
   logic        gen_available;
   logic [31:0] rsp_write;
   logic [31:0] rsp_clean;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data;
   logic [31:0] out_mask;
   logic [9:0]  out_index;

   int vectors     = 0;
   int miscompares = 0;

   logic        stuck;
   logic        stub_clr;
   logic [31:0] pat  [5];
   logic [31:0] cpat [5];
   int          k;
   int          dly;

   rwc_chal_seq #(.NUM_CHAL(2), .REPS(5), .TIMEOUT(TO)) dut (
      .clk           (clk),
      .w_resetn      (w_resetn),
      .start         (start),
      .seed          (seed),
      .busy          (busy),
      .done          (done),
      .err           (err),
      .clean_err     (clean_err),
      .gen_enable    (gen_enable),
      .cha_data      (cha_data),
      .cha_addr      (cha_addr),
      .gen_available (gen_available),
      .rsp_write     (rsp_write),
      .rsp_clean     (rsp_clean),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_data      (out_data),
      .out_mask      (out_mask),
      .out_index     (out_index)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Generator stub: busy for two cycles per request, response from table
   always @(posedge clk) begin
      if (!w_resetn || stub_clr) begin
         gen_available <= 1'b1;
         k             <= 0;
         dly           <= 0;
         rsp_write     <= 32'd0;
         rsp_clean     <= 32'd0;
      end else if (gen_enable && !stuck) begin
         gen_available <= 1'b0;
         dly           <= 2;
         rsp_write     <= pat[k];
         rsp_clean     <= cpat[k];
         k             <= (k == 4) ? 0 : k + 1;
      end else if (dly != 0) begin
         dly <= dly - 1;
         if (dly == 1)
            gen_available <= 1'b1;
      end
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic do_start(input logic [31:0] s, input logic [31:0] exp_data, input string tag);
      seed     = s;
      start    = 1'b1;
      stub_clr = 1'b1;
      tick();
      start    = 1'b0;
      stub_clr = 1'b0;
      check({tag, " busy"}, {31'd0, busy}, 32'd1);
      check({tag, " gen_enable"}, {31'd0, gen_enable}, 32'd1);
      check({tag, " cha_data"}, cha_data, exp_data);
      check({tag, " cha_addr"}, {22'd0, cha_addr}, {22'd0, exp_data[9:0]});
   endtask

   task automatic wait_valid(input string tag);
      int n;
      n = 0;
      while (out_valid !== 1'b1 && n < 300) begin
         tick();
         n++;
      end
      check(tag, {31'd0, out_valid}, 32'd1);
   endtask

   task automatic check_emit(input string tag, input logic [31:0] d, input logic [31:0] m,
                             input logic [9:0] idx);
      check({tag, " out_data"}, out_data, d);
      check({tag, " out_mask"}, out_mask, m);
      check({tag, " out_index"}, {22'd0, out_index}, {22'd0, idx});
      $display("emit %s: index=%0d data=0x%08h mask=0x%08h", tag, out_index, out_data, out_mask);
   endtask

   task automatic handshake;
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, " busy"}, {31'd0, busy}, 32'd0);
      check({tag, " done"}, {31'd0, done}, 32'd0);
      check({tag, " err"}, {31'd0, err}, 32'd0);
      check({tag, " clean_err"}, {31'd0, clean_err}, 32'd0);
      check({tag, " gen_enable"}, {31'd0, gen_enable}, 32'd0);
      check({tag, " cha_data"}, cha_data, 32'd0);
      check({tag, " cha_addr"}, {22'd0, cha_addr}, 32'd0);
      check({tag, " out_valid"}, {31'd0, out_valid}, 32'd0);
      check({tag, " out_data"}, out_data, 32'd0);
      check({tag, " out_mask"}, out_mask, 32'd0);
      check({tag, " out_index"}, {22'd0, out_index}, 32'd0);
   endtask

   initial begin
      int n;
      w_resetn  = 1'b0;
      start     = 1'b0;
      seed      = 32'd0;
      out_ready = 1'b0;
      stuck     = 1'b0;
      stub_clr  = 1'b0;
      for (int i = 0; i < 5; i++) begin
         pat[i]  = 32'd0;
         cpat[i] = 32'd0;
      end

      // Reset state
      repeat (3) tick();
      check_all_zero("reset");
      w_resetn = 1'b1;
      tick();

      // Run 1: seed 0 -> LFSR 1; unanimous pattern, then 2-of-5 on bit 0
      for (int i = 0; i < 5; i++) pat[i] = 32'hA5A5_5A5A;
      do_start(32'd0, 32'h0000_0001, "r1 start");
      wait_valid("r1c0 valid");
      check_emit("r1c0", 32'hA5A5_5A5A, 32'hFFFF_FFFF, 10'd0);
      pat[0] = 32'd1; pat[1] = 32'd0; pat[2] = 32'd1; pat[3] = 32'd0; pat[4] = 32'd0;
      // Backpressure: everything held, no new generation request
      for (int c = 0; c < 10; c++) begin
         tick();
         check("bp out_valid", {31'd0, out_valid}, 32'd1);
         check("bp out_data", out_data, 32'hA5A5_5A5A);
         check("bp out_mask", out_mask, 32'hFFFF_FFFF);
         check("bp out_index", {22'd0, out_index}, 32'd0);
         check("bp gen_enable", {31'd0, gen_enable}, 32'd0);
      end
      handshake();
      check("r1 hs0 out_valid", {31'd0, out_valid}, 32'd0);
      check("r1 hs0 gen_enable", {31'd0, gen_enable}, 32'd1);
      check("r1c1 cha_data", cha_data, 32'h8020_0003);
      check("r1c1 cha_addr", {22'd0, cha_addr}, 32'h0000_0003);
      check("r1 hs0 done", {31'd0, done}, 32'd0);
      wait_valid("r1c1 valid");
      check_emit("r1c1", 32'h0000_0000, 32'hFFFF_FFFE, 10'd1);
      handshake();
      check("r1 end done", {31'd0, done}, 32'd1);
      check("r1 end out_valid", {31'd0, out_valid}, 32'd0);
      check("r1 end busy", {31'd0, busy}, 32'd1);
      check("r1 end err", {31'd0, err}, 32'd0);
      tick();
      check("r1 post done", {31'd0, done}, 32'd0);
      check("r1 post busy", {31'd0, busy}, 32'd0);

      // Run 2: 3-of-5 on bit 0 with clear-phase noise, then a mixed pattern
      pat[0] = 32'd1; pat[1] = 32'd1; pat[2] = 32'd1; pat[3] = 32'd0; pat[4] = 32'd0;
      cpat[2] = 32'h0000_0010;
      do_start(32'h1234_5678, 32'h1234_5678, "r2 start");
      seed  = 32'hDEAD_BEEF;
      start = 1'b1;
      tick();
      start = 1'b0;
      check("busy start ignored cha_data", cha_data, 32'h1234_5678);
      check("busy start ignored busy", {31'd0, busy}, 32'd1);
      wait_valid("r2c0 valid");
      check_emit("r2c0", 32'h0000_0001, 32'hFFFF_FFFE, 10'd0);
      check("r2c0 clean_err", {31'd0, clean_err}, CLEAN_EXP);
      cpat[2] = 32'd0;
      pat[0] = 32'h0000_00F0; pat[1] = 32'h0000_00CC; pat[2] = 32'h0000_00AA;
      pat[3] = 32'h0000_00FF; pat[4] = 32'h0000_0000;
      handshake();
      check("r2c1 cha_data", cha_data, 32'h091A_2B3C);
      check("r2c1 cha_addr", {22'd0, cha_addr}, 32'h0000_033C);
      wait_valid("r2c1 valid");
      check_emit("r2c1", 32'h0000_00E8, 32'hFFFF_FF00, 10'd1);
      check("r2c1 clean_err sticky", {31'd0, clean_err}, CLEAN_EXP);
      handshake();
      check("r2 end done", {31'd0, done}, 32'd1);
      tick();

      // Run 3: generator never drops gen_available -> timeout
      stuck = 1'b1;
      do_start(32'd5, 32'd5, "r3 start");
      tick();
      n = 0;
      while (done !== 1'b1 && n < 200) begin
         tick();
         n++;
      end
      check("timeout cycles", n, TO);
      check("timeout err", {31'd0, err}, 32'd1);
      check("timeout busy during done", {31'd0, busy}, 32'd1);
      tick();
      check("timeout post busy", {31'd0, busy}, 32'd0);
      check("timeout post done", {31'd0, done}, 32'd0);
      check("timeout err sticky", {31'd0, err}, 32'd1);
      stuck = 1'b0;

      // Run 4: new start clears flags; reset in WAIT_HI clears everything
      do_start(32'd3, 32'd3, "r4 start");
      check("r4 err cleared", {31'd0, err}, 32'd0);
      check("r4 clean_err cleared", {31'd0, clean_err}, 32'd0);
      tick();
      tick();
      check("r4 pre-reset out_data", out_data, 32'h0000_00E8);
      w_resetn = 1'b0;
      tick();
      check_all_zero("mid-run reset");
      w_resetn = 1'b1;
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
